// File: rtl/demux32_1to2.sv
// One-to-two stream demultiplexer. Each output has a one-entry register slot,
// and each output keeps a wrapping count of its transfers.
module demux32_1to2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             control,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    logic [WIDTH-1:0] data_reg [2];
    logic [CNT_W-1:0] cnt_reg  [2];
    logic [1:0]       valid_reg;
    logic [1:0]       out_ready;
    logic [1:0]       sel;
    logic [1:0]       slot_free;
    logic [1:0]       accept;
    logic [1:0]       xfer;

    assign out_ready = {out2_ready, out1_ready};
    assign sel       = {control, ~control};

    // A slot can take a new word if it is empty or is being drained this edge.
    assign in_ready = |(sel & slot_free);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            assign slot_free[gi] = ~valid_reg[gi] | out_ready[gi];
            assign accept[gi]    = in_valid & sel[gi] & slot_free[gi];
            assign xfer[gi]      = valid_reg[gi] & out_ready[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg[gi]  <= '0;
                    valid_reg[gi] <= 1'b0;
                    cnt_reg[gi]   <= '0;
                end else begin
                    if (accept[gi]) begin
                        data_reg[gi]  <= in_data;
                        valid_reg[gi] <= 1'b1;
                    end else if (xfer[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (xfer[gi]) begin
                        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign out1_data  = data_reg[0];
    assign out1_valid = valid_reg[0];
    assign cnt1       = cnt_reg[0];
    assign out2_data  = data_reg[1];
    assign out2_valid = valid_reg[1];
    assign cnt2       = cnt_reg[1];

endmodule

// File: tb/tb_demux32_1to2.sv
// Bench for demux32_1to2: directed vector table, reset/wrap sequences and a
// randomized run scored against per-channel queues.
module tb_demux32_1to2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        control;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    demux32_1to2 #(.WIDTH(32), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .control    (control),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ctl;
        logic [31:0] d;
        logic        r1;
        logic        r2;
        logic        e_ir;
        logic        e_v1;
        logic [31:0] e_d1;
        logic        e_v2;
        logic [31:0] e_d2;
        logic [7:0]  e_c1;
        logic [7:0]  e_c2;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ctl, input logic [31:0] d,
                         input logic r1, input logic r2);
        in_valid   = iv;
        control    = ctl;
        in_data    = d;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    int          mc1;
    int          mc2;
    logic        e_ir;

    initial begin
        // Directed table, applied back to back from the reset state.
        vt[0]  = '{1'b1, 1'b0, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 8'd0, 8'd0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0, 8'd1, 8'd0};
        vt[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 8'd1, 8'd0};
        vt[3]  = '{1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 8'd1, 8'd0};
        vt[4]  = '{1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_0001, 8'd1, 8'd1};
        vt[5]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0000_0001, 8'd1, 8'd2};
        vt[6]  = '{1'b1, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_AAAA, 8'd1, 8'd2};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_0011, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0011, 1'b1, 32'h0000_AAAA, 8'd1, 8'd2};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_0022, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0022, 1'b1, 32'h0000_AAAA, 8'd2, 8'd2};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0033, 1'b1, 32'h0000_AAAA, 8'd3, 8'd2};
        vt[10] = '{1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_AAAA, 8'd4, 8'd2};
        vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_AAAA, 8'd5, 8'd2};
        vt[12] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_AAAA, 8'd5, 8'd2};

        do_reset();
        chk("rst_v1", out1_valid, 1'b0);
        chk("rst_v2", out2_valid, 1'b0);
        chk("rst_c1", cnt1, 8'd0);
        chk("rst_ir", in_ready, 1'b1);

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].iv, vt[i].ctl, vt[i].d, vt[i].r1, vt[i].r2);
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ir);
            step();
            chk($sformatf("v%0d_out1_valid", i), out1_valid, vt[i].e_v1);
            chk($sformatf("v%0d_out1_data", i), out1_data, vt[i].e_d1);
            chk($sformatf("v%0d_out2_valid", i), out2_valid, vt[i].e_v2);
            chk($sformatf("v%0d_out2_data", i), out2_data, vt[i].e_d2);
            chk($sformatf("v%0d_cnt1", i), cnt1, vt[i].e_c1);
            chk($sformatf("v%0d_cnt2", i), cnt2, vt[i].e_c2);
            $display("vec %0d iv=%0b ctl=%0b d=%h -> o1=%0b/%h o2=%0b/%h c1=%0d c2=%0d",
                     i, vt[i].iv, vt[i].ctl, vt[i].d, out1_valid, out1_data,
                     out2_valid, out2_data, cnt1, cnt2);
        end

        // Reset between edges with both slots full clears everything at once.
        drive(1'b1, 1'b0, 32'h0000_5555, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("amid_v1", out1_valid, 1'b0);
        chk("amid_v2", out2_valid, 1'b0);
        chk("amid_d1", out1_data, 32'h0);
        chk("amid_d2", out2_data, 32'h0);
        chk("amid_c1", cnt1, 8'd0);
        chk("amid_c2", cnt2, 8'd0);
        control = 1'b0;
        #1;
        chk("amid_ir0", in_ready, 1'b1);
        control = 1'b1;
        #1;
        chk("amid_ir1", in_ready, 1'b1);
        $display("mid-op reset: o1=%0b o2=%0b c1=%0d c2=%0d", out1_valid, out2_valid, cnt1, cnt2);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_7777, 1'b0, 1'b0);
        step();
        chk("first_accept_v2", out2_valid, 1'b1);
        chk("first_accept_d2", out2_data, 32'h0000_7777);
        $display("first accept after reset: o2=%0b/%h", out2_valid, out2_data);

        // Counter wrap: 256 back-to-back channel-1 transfers.
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int n = 1; n <= 256; n++) begin
            in_data = n;
            step();
        end
        chk("wrap_255", cnt1, 8'd255);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("wrap_0", cnt1, 8'd0);
        chk("wrap_c2", cnt2, 8'd0);
        $display("counter wrap: cnt1=%0d cnt2=%0d", cnt1, cnt2);

        // Random traffic scored against per-channel queues of accepted words.
        do_reset();
        q1.delete();
        q2.delete();
        mc1 = 0;
        mc2 = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            #2;
            e_ir = control ? (q2.size() == 0 || out2_ready) : (q1.size() == 0 || out1_ready);
            chk("rnd_in_ready", in_ready, e_ir);
            chk("rnd_out1_valid", out1_valid, q1.size() != 0);
            chk("rnd_out2_valid", out2_valid, q2.size() != 0);
            if (q1.size() != 0) chk("rnd_out1_data", out1_data, q1[0]);
            if (q2.size() != 0) chk("rnd_out2_data", out2_data, q2[0]);
            chk("rnd_cnt1", cnt1, mc1 % 256);
            chk("rnd_cnt2", cnt2, mc2 % 256);
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                mc1++;
            end
            if (q2.size() != 0 && out2_ready) begin
                void'(q2.pop_front());
                mc2++;
            end
            if (in_valid && e_ir) begin
                if (control) q2.push_back(in_data);
                else         q1.push_back(in_data);
            end
            step();
        end
        $display("random run: transfers ch1=%0d ch2=%0d", mc1, mc2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux32_1to2.md
DEMUX32_1TO2 -- requirements
Module: demux32_1to2

Interface
REQ-001 Parameter: WIDTH, 32, data path width in bits.
REQ-002 Parameter: CNT_W, 8, width of each per-channel transfer counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  word to be routed.
REQ-006 Port: in_valid  input  1  in_data/control valid this cycle.
REQ-007 Port: control  input  1  destination select, sampled with in_data; 0 selects channel 1, 1 selects channel 2.
REQ-008 Port: in_ready  output  1  word accepted this cycle when in_valid and in_ready are both 1.
REQ-009 Port: out1_data  output  WIDTH  channel-1 registered word.
REQ-010 Port: out1_valid  output  1  channel-1 word present.
REQ-011 Port: out1_ready  input  1  channel-1 consumer takes the word.
REQ-012 Port: out2_data  output  WIDTH  channel-2 registered word.
REQ-013 Port: out2_valid  output  1  channel-2 word present.
REQ-014 Port: out2_ready  input  1  channel-2 consumer takes the word.
REQ-015 Port: cnt1  output  CNT_W  count of channel-1 output transfers, modulo 2^CNT_W.
REQ-016 Port: cnt2  output  CNT_W  count of channel-2 output transfers, modulo 2^CNT_W.

Function
REQ-017 Each channel SHALL hold a one-entry register slot with states EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-018 Output transfer on channel N SHALL occur when outN_valid and outN_ready are both 1 on a rising edge.
REQ-019 in_ready SHALL be combinational: with control=0, it is (!out1_valid | out1_ready); with control=1, it is (!out2_valid | out2_ready).
REQ-020 On an accept, the selected slot SHALL load in_data and go FULL at that edge, giving 1-cycle latency from accept to outN_valid.
REQ-021 Slot transitions: EMPTY->FULL on accept; FULL->EMPTY on output transfer without accept; FULL->FULL with new data on simultaneous transfer and accept.
REQ-022 The non-selected slot SHALL be unaffected by an accept; its data, valid and pending transfer proceed independently.
REQ-023 A stalled channel SHALL NOT block traffic routed to the other channel.
REQ-024 While outN_valid=1 and outN_ready=0, outN_data SHALL remain stable.
REQ-025 Words SHALL leave each channel in acceptance order; no word SHALL be dropped or duplicated.
REQ-026 When in_valid=0, no slot SHALL load, regardless of control or in_ready.
REQ-027 cntN SHALL increment by 1 on each channel-N output transfer and wrap from 2^CNT_W-1 to 0.
REQ-028 outN_ready SHALL be ignored while outN_valid=0 (no transfer, no count).
REQ-029 Both channels MAY transfer in the same cycle; both counters SHALL then increment.

Reset
REQ-030 While reset=1, the block SHALL force: out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, cnt1=0, cnt2=0, independent of clk.
REQ-031 With reset=1 or immediately after release, in_ready SHALL equal 1 for either control value.
REQ-032 Reset asserted mid-operation SHALL discard any held words with no transfer counted.
REQ-033 The first accept SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-034 Basic route: in_data=0x0000_1234, control=0, in_valid=1 for one cycle, out1_ready=1 -> out1_valid=1 with out1_data=0x0000_1234 one cycle later; out2_valid stays 0; cnt1=1 after the transfer.
REQ-035 Stall and hold: out2_ready=0; accept 0xDEAD_BEEF with control=1, then present 0x1 with control=1 -> in_ready=0, out2_data holds 0xDEAD_BEEF; raise out2_ready -> same-cycle refill, out2_data=0x1 next cycle, out2_valid stays 1.
REQ-036 Independence: out2 stalled FULL; stream 4 words with control=0, out1_ready=1 -> all 4 words appear on out1 in order; out2 unchanged; cnt1=4, cnt2=0.
REQ-037 Counter wrap: 256 channel-1 transfers with CNT_W=8 -> cnt1 reads 255 then 0.
REQ-038 Reset mid-operation: both slots FULL, assert reset between edges -> valids, data and counters read 0 before the next edge; in_ready=1.
REQ-039 Random: random in_valid, control and outN_ready over 10k cycles -> scoreboard confirms per-channel order, no loss or duplication, and cntN equal to the observed transfers modulo 256.
